// File: rtl/iram_isp_loader.sv
// rtl/iram_isp_loader.sv - ISP loader: byte-stream framed image to iram AXI4-Lite writes
//
// Purpose:
//   Parses a little-endian framed image (length word, payload words,
//   checksum word) from a byte stream and writes each payload word into
//   instruction RAM through the AXI4-Lite write channels. It never reads.
//   Reports done or an error code to the ISP boot code.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   isp_en_i                         arm loader; low aborts / clears status
//   rx_data_i, rx_valid_i, rx_ready_o  byte stream in
//   isp_axi_aw*, isp_axi_w*, isp_axi_b*  AXI4-Lite write channels to iram
//   busy_o, done_o, err_o, err_code_o  frame status
//   word_cnt_o                       payload words written so far
module iram_isp_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 8192,
   parameter logic [23:0] TIMEOUT   = 24'd1_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        isp_en_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   output logic [31:0] isp_axi_awaddr,
   output logic [2:0]  isp_axi_awprot,
   output logic        isp_axi_awvalid,
   input  logic        isp_axi_awready,
   output logic [31:0] isp_axi_wdata,
   output logic [3:0]  isp_axi_wstrb,
   output logic        isp_axi_wvalid,
   input  logic        isp_axi_wready,
   input  logic [1:0]  isp_axi_bresp,
   input  logic        isp_axi_bvalid,
   output logic        isp_axi_bready,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [2:0]  err_code_o,
   output logic [15:0] word_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_DATA, S_WR, S_WAIT_B, S_CSUM, S_DONE, S_ERR
   } state_t;

   localparam logic [2:0] ERR_LEN  = 3'd1;
   localparam logic [2:0] ERR_CSUM = 3'd2;
   localparam logic [2:0] ERR_RESP = 3'd3;
   localparam logic [2:0] ERR_TMO  = 3'd4;

   state_t      state_q;
   logic [1:0]  byte_idx_q;
   logic [23:0] shift_q;      // bytes 0..2 of the word being assembled
   logic [31:0] len_q;
   logic [31:0] sum_q;
   logic [31:0] wdata_q;
   logic [31:0] awaddr_q;
   logic        awvalid_q;
   logic        wvalid_q;
   logic        bready_q;
   logic        done_q;
   logic        err_q;
   logic [2:0]  err_code_q;
   logic [15:0] word_cnt_q;
   logic [23:0] idle_cnt_q;
   logic        abort_q;      // isp_en_i dropped while an AXI write was in flight

   logic        rx_phase;
   logic        byte_fire;
   logic        word_fire;
   logic [31:0] rx_word;
   logic        tmo_hit;
   logic        b_fire;
   logic        to_idle;
   logic [15:0] word_cnt_d;

   assign rx_phase   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
   assign rx_ready_o = rx_phase && isp_en_i;
   assign byte_fire  = rx_valid_i && rx_ready_o;
   assign word_fire  = byte_fire && (byte_idx_q == 2'd3);
   assign rx_word    = {rx_data_i, shift_q};
   assign word_cnt_d = word_cnt_q + 16'd1;
   assign b_fire     = (state_q == S_WAIT_B) && isp_axi_bvalid && bready_q;

   // The counter holds the number of idle cycles already elapsed; the
   // TIMEOUT-th idle edge is the one that aborts.
   assign tmo_hit = (TIMEOUT != 24'd0) && rx_phase && !byte_fire &&
                    (idle_cnt_q == TIMEOUT - 24'd1);

   // Abort exits: byte-phase states and the terminal states leave at once;
   // an in-flight write is only abandoned after its B response is taken.
   assign to_idle = (!isp_en_i && (rx_phase || state_q == S_DONE || state_q == S_ERR)) ||
                    (b_fire && (abort_q || !isp_en_i));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         byte_idx_q <= 2'd0;
         shift_q    <= 24'd0;
         len_q      <= 32'd0;
         sum_q      <= 32'd0;
         wdata_q    <= 32'd0;
         awaddr_q   <= 32'd0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         bready_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 3'd0;
         word_cnt_q <= 16'd0;
         idle_cnt_q <= 24'd0;
         abort_q    <= 1'b0;
      end else begin
         // Byte assembly; the index restarts whenever a byte phase is left.
         if (!rx_phase) begin
            byte_idx_q <= 2'd0;
         end else if (byte_fire) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
               2'd0:    shift_q[7:0]   <= rx_data_i;
               2'd1:    shift_q[15:8]  <= rx_data_i;
               2'd2:    shift_q[23:16] <= rx_data_i;
               default: ;
            endcase
         end

         if (!rx_phase || byte_fire) idle_cnt_q <= 24'd0;
         else                        idle_cnt_q <= idle_cnt_q + 24'd1;

         if ((state_q == S_WR || state_q == S_WAIT_B) && !isp_en_i) abort_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               abort_q <= 1'b0;
               if (isp_en_i && !done_q && !err_q) state_q <= S_LEN;
            end
            S_LEN: begin
               if (tmo_hit) begin
                  err_q <= 1'b1; err_code_q <= ERR_TMO; state_q <= S_ERR;
               end else if (word_fire) begin
                  len_q <= rx_word;
                  if (rx_word == 32'd0 || rx_word > 32'(MAX_WORDS)) begin
                     err_q <= 1'b1; err_code_q <= ERR_LEN; state_q <= S_ERR;
                  end else begin
                     word_cnt_q <= 16'd0;
                     sum_q      <= 32'd0;
                     state_q    <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (tmo_hit) begin
                  err_q <= 1'b1; err_code_q <= ERR_TMO; state_q <= S_ERR;
               end else if (word_fire) begin
                  wdata_q   <= rx_word;
                  awaddr_q  <= BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
                  awvalid_q <= 1'b1;
                  wvalid_q  <= 1'b1;
                  state_q   <= S_WR;
               end
            end
            S_WR: begin
               // AW and W complete independently; move on once neither is pending.
               if (awvalid_q && isp_axi_awready) awvalid_q <= 1'b0;
               if (wvalid_q && isp_axi_wready)   wvalid_q  <= 1'b0;
               if ((!awvalid_q || isp_axi_awready) && (!wvalid_q || isp_axi_wready)) begin
                  bready_q <= 1'b1;
                  state_q  <= S_WAIT_B;
               end
            end
            S_WAIT_B: begin
               if (b_fire) begin
                  bready_q <= 1'b0;
                  if (isp_axi_bresp != 2'b00) begin
                     err_q <= 1'b1; err_code_q <= ERR_RESP; state_q <= S_ERR;
                  end else begin
                     sum_q      <= sum_q + wdata_q;
                     word_cnt_q <= word_cnt_d;
                     state_q    <= ({16'd0, word_cnt_d} == len_q) ? S_CSUM : S_DATA;
                  end
               end
            end
            S_CSUM: begin
               if (tmo_hit) begin
                  err_q <= 1'b1; err_code_q <= ERR_TMO; state_q <= S_ERR;
               end else if (word_fire) begin
                  if (rx_word == sum_q) begin
                     done_q <= 1'b1; state_q <= S_DONE;
                  end else begin
                     err_q <= 1'b1; err_code_q <= ERR_CSUM; state_q <= S_ERR;
                  end
               end
            end
            default: ;  // S_DONE / S_ERR wait for isp_en_i to drop
         endcase

         // Returning to IDLE always clears the reported status.
         if (to_idle) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 3'd0;
            word_cnt_q <= 16'd0;
            abort_q    <= 1'b0;
         end
      end
   end

   assign isp_axi_awaddr  = awaddr_q;
   assign isp_axi_awprot  = 3'b000;
   assign isp_axi_awvalid = awvalid_q;
   assign isp_axi_wdata   = wdata_q;
   assign isp_axi_wstrb   = 4'hF;
   assign isp_axi_wvalid  = wvalid_q;
   assign isp_axi_bready  = bready_q;
   assign busy_o          = rx_phase || (state_q == S_WR) || (state_q == S_WAIT_B);
   assign done_o          = done_q;
   assign err_o           = err_q;
   assign err_code_o      = err_code_q;
   assign word_cnt_o      = word_cnt_q;

endmodule

// File: tb/tb_iram_isp_loader.sv
// tb/tb_iram_isp_loader.sv - self-checking bench for iram_isp_loader
module tb_iram_isp_loader;

   localparam logic [31:0] BASE = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        isp_en_i = 1'b0;
   logic [7:0]  rx_data_i = 8'd0;
   logic        rx_valid_i = 1'b0;
   logic        rx_ready_o;
   logic [31:0] isp_axi_awaddr;
   logic [2:0]  isp_axi_awprot;
   logic        isp_axi_awvalid;
   logic        isp_axi_awready = 1'b0;
   logic [31:0] isp_axi_wdata;
   logic [3:0]  isp_axi_wstrb;
   logic        isp_axi_wvalid;
   logic        isp_axi_wready = 1'b0;
   logic [1:0]  isp_axi_bresp = 2'b00;
   logic        isp_axi_bvalid = 1'b0;
   logic        isp_axi_bready;
   logic        busy_o, done_o, err_o;
   logic [2:0]  err_code_o;
   logic [15:0] word_cnt_o;

   iram_isp_loader #(
      .BASE_ADDR(BASE), .MAX_WORDS(8192), .TIMEOUT(24'd100)
   ) dut (
      .clk(clk), .rst_n(rst_n), .isp_en_i(isp_en_i),
      .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
      .isp_axi_awaddr(isp_axi_awaddr), .isp_axi_awprot(isp_axi_awprot),
      .isp_axi_awvalid(isp_axi_awvalid), .isp_axi_awready(isp_axi_awready),
      .isp_axi_wdata(isp_axi_wdata), .isp_axi_wstrb(isp_axi_wstrb),
      .isp_axi_wvalid(isp_axi_wvalid), .isp_axi_wready(isp_axi_wready),
      .isp_axi_bresp(isp_axi_bresp), .isp_axi_bvalid(isp_axi_bvalid),
      .isp_axi_bready(isp_axi_bready),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .err_code_o(err_code_o), .word_cnt_o(word_cnt_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // scoreboard
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   logic [31:0] obs_addr_q[$];
   logic [31:0] obs_data_q[$];
   logic [3:0]  obs_strb_q[$];

   // slave configuration
   int          aw_delay = 0;
   int          w_delay = 0;
   int          b_delay = 0;
   logic [1:0]  bresp_val = 2'b00;

   // slave state
   logic        got_aw = 1'b0, got_w = 1'b0;
   int          aw_wait = 0, w_wait = 0, b_wait = 0;
   logic [31:0] cap_addr = 32'd0, cap_data = 32'd0;
   logic [3:0]  cap_strb = 4'd0;
   int          b_hs = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         isp_axi_awready <= 1'b0; isp_axi_wready <= 1'b0; isp_axi_bvalid <= 1'b0;
         isp_axi_bresp <= 2'b00; got_aw <= 1'b0; got_w <= 1'b0;
         aw_wait <= 0; w_wait <= 0; b_wait <= 0;
      end else begin
         if (isp_axi_awready && isp_axi_awvalid) begin
            isp_axi_awready <= 1'b0; got_aw <= 1'b1; cap_addr <= isp_axi_awaddr;
         end else if (isp_axi_awvalid && !got_aw && !isp_axi_awready) begin
            if (aw_wait >= aw_delay) isp_axi_awready <= 1'b1;
            else aw_wait <= aw_wait + 1;
         end
         if (isp_axi_wready && isp_axi_wvalid) begin
            isp_axi_wready <= 1'b0; got_w <= 1'b1;
            cap_data <= isp_axi_wdata; cap_strb <= isp_axi_wstrb;
         end else if (isp_axi_wvalid && !got_w && !isp_axi_wready) begin
            if (w_wait >= w_delay) isp_axi_wready <= 1'b1;
            else w_wait <= w_wait + 1;
         end
         if (got_aw && got_w && !isp_axi_bvalid) begin
            if (b_wait >= b_delay) begin
               isp_axi_bvalid <= 1'b1; isp_axi_bresp <= bresp_val;
               obs_addr_q.push_back(cap_addr);
               obs_data_q.push_back(cap_data);
               obs_strb_q.push_back(cap_strb);
            end else b_wait <= b_wait + 1;
         end
         if (isp_axi_bvalid && isp_axi_bready) begin
            isp_axi_bvalid <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0;
            aw_wait <= 0; w_wait <= 0; b_wait <= 0;
            b_hs <= b_hs + 1;
         end
      end
   end

   // protocol monitors, sampled mid-cycle
   int   cyc = 0, aw_fall_t = 0, w_fall_t = 0, rdy_viol = 0, act_cnt = 0, hold_viol = 0;
   logic prev_aw = 1'b0, prev_awr = 1'b0, prev_w = 1'b0, prev_wr = 1'b0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (prev_aw && !isp_axi_awvalid) aw_fall_t = cyc;
      if (prev_w && !isp_axi_wvalid)   w_fall_t = cyc;
      if (rst_n && prev_aw && !prev_awr && !isp_axi_awvalid) hold_viol = hold_viol + 1;
      if (rst_n && prev_w && !prev_wr && !isp_axi_wvalid)    hold_viol = hold_viol + 1;
      if (rx_ready_o && (isp_axi_awvalid || isp_axi_wvalid || isp_axi_bready)) rdy_viol = rdy_viol + 1;
      if (isp_axi_awvalid || isp_axi_wvalid) act_cnt = act_cnt + 1;
      prev_aw = isp_axi_awvalid; prev_awr = isp_axi_awready;
      prev_w = isp_axi_wvalid;   prev_wr = isp_axi_wready;
   end

   // stimulus
   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      rx_data_i = b; rx_valid_i = 1'b1;
      for (int n = 0; n < 300 && !ok; n++) begin
         @(negedge clk);
         if (rx_ready_o) begin @(posedge clk); #1; ok = 1'b1; end
      end
      rx_valid_i = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL byte_accept: byte %02h not taken within bound", b); end
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic send_data(input logic [31:0] w, input int idx);
      exp_addr_q.push_back(BASE + 32'(idx * 4));
      exp_data_q.push_back(w);
      send_word(w);
   endtask

   task automatic wait_status();
      for (int n = 0; n < 400 && !(done_o || err_o); n++) @(negedge clk);
   endtask

   task automatic disarm();
      isp_en_i = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // tests
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({rx_ready_o, isp_axi_awaddr, isp_axi_awprot, isp_axi_awvalid, isp_axi_wdata, isp_axi_wstrb,
           isp_axi_wvalid, isp_axi_bready, busy_o, done_o, err_o, err_code_o, word_cnt_o}
          !== {1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0}) begin
         errors++;
         $display("FAIL reset_state: rdy=%b aw=%h/%b w=%h/%h/%b busy=%b done=%b err=%b code=%0d cnt=%0d, want all 0, wstrb F",
                  rx_ready_o, isp_axi_awaddr, isp_axi_awvalid, isp_axi_wdata, isp_axi_wstrb, isp_axi_wvalid,
                  busy_o, done_o, err_o, err_code_o, word_cnt_o);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy_o, rx_ready_o} !== 2'b00) begin
         errors++; $display("FAIL idle_unarmed: busy=%b rdy=%b, want 0 0", busy_o, rx_ready_o);
      end
   endtask

   task automatic test_good_frame();
      logic [31:0] ea, ed;
      isp_en_i = 1'b1;
      send_word(32'd2);
      send_data(32'h0000_0013, 0);
      send_data(32'h1234_5678, 1);
      send_word(32'h1234_568B);
      wait_status();
      checks++;
      if ({done_o, err_o, word_cnt_o} !== {1'b1, 1'b0, 16'd2}) begin
         errors++; $display("FAIL good_status: done=%b err=%b cnt=%0d, want 1 0 2", done_o, err_o, word_cnt_o);
      end
      while (exp_addr_q.size() != 0) begin
         ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
         checks++;
         if (obs_addr_q.size() == 0) begin errors++; $display("FAIL good_write: missing write to %08h", ea); end
         else if ({obs_addr_q[0], obs_data_q[0], obs_strb_q[0]} !== {ea, ed, 4'hF}) begin
            errors++; $display("FAIL good_write: got %08h/%08h/%h want %08h/%08h/F",
                               obs_addr_q[0], obs_data_q[0], obs_strb_q[0], ea, ed);
         end
         if (obs_addr_q.size() != 0) begin
            void'(obs_addr_q.pop_front()); void'(obs_data_q.pop_front()); void'(obs_strb_q.pop_front());
         end
      end
      disarm();
      checks++;
      if ({done_o, err_o, err_code_o, word_cnt_o, busy_o} !== 22'd0) begin
         errors++; $display("FAIL status_clear: done=%b err=%b code=%0d cnt=%0d busy=%b, want all 0",
                            done_o, err_o, err_code_o, word_cnt_o, busy_o);
      end
   endtask

   task automatic test_bad_checksum();
      logic [31:0] ea, ed;
      isp_en_i = 1'b1;
      send_word(32'd2);
      send_data(32'h0000_0013, 0);
      send_data(32'h1234_5678, 1);
      send_word(32'h0000_0000);
      wait_status();
      checks++;
      if ({done_o, err_o, err_code_o} !== {1'b0, 1'b1, 3'd2}) begin
         errors++; $display("FAIL csum_err: done=%b err=%b code=%0d, want 0 1 2", done_o, err_o, err_code_o);
      end
      while (exp_addr_q.size() != 0) begin
         ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
         checks++;
         if (obs_addr_q.size() == 0) begin errors++; $display("FAIL csum_write: missing write to %08h", ea); end
         else begin
            if ({obs_addr_q[0], obs_data_q[0]} !== {ea, ed}) begin
               errors++; $display("FAIL csum_write: got %08h/%08h want %08h/%08h", obs_addr_q[0], obs_data_q[0], ea, ed);
            end
            void'(obs_addr_q.pop_front()); void'(obs_data_q.pop_front()); void'(obs_strb_q.pop_front());
         end
      end
      disarm();
   endtask

   task automatic test_bad_length();
      int act0;
      act0 = act_cnt;
      isp_en_i = 1'b1;
      send_word(32'd0);
      checks++;
      if ({rx_ready_o, err_o, err_code_o} !== {1'b0, 1'b1, 3'd1}) begin
         errors++; $display("FAIL len_zero: rdy=%b err=%b code=%0d, want 0 1 1", rx_ready_o, err_o, err_code_o);
      end
      disarm();
      isp_en_i = 1'b1;
      send_word(32'd8193);
      checks++;
      if ({rx_ready_o, err_o, err_code_o} !== {1'b0, 1'b1, 3'd1}) begin
         errors++; $display("FAIL len_big: rdy=%b err=%b code=%0d, want 0 1 1", rx_ready_o, err_o, err_code_o);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (act_cnt != act0) begin errors++; $display("FAIL len_no_axi: %0d valid cycles, want 0", act_cnt - act0); end
      disarm();
   endtask

   task automatic test_slow_slave();
      logic [31:0] ea, ed;
      int rdy0;
      aw_delay = 0; w_delay = 3; b_delay = 5;
      rdy0 = rdy_viol;
      isp_en_i = 1'b1;
      send_word(32'd2);
      send_data(32'hA5A5_0001, 0);
      send_data(32'h0000_FFFF, 1);
      send_word(32'hA5A6_0000);
      wait_status();
      checks++;
      if ({done_o, err_o, word_cnt_o} !== {1'b1, 1'b0, 16'd2}) begin
         errors++; $display("FAIL slow_status: done=%b err=%b cnt=%0d, want 1 0 2", done_o, err_o, word_cnt_o);
      end
      checks++;
      if (!(aw_fall_t != 0 && aw_fall_t < w_fall_t)) begin
         errors++; $display("FAIL slow_order: awvalid fell at %0d, wvalid at %0d, want aw earlier", aw_fall_t, w_fall_t);
      end
      checks++;
      if (rdy_viol != rdy0) begin errors++; $display("FAIL slow_backpressure: rx_ready high in %0d AXI cycles, want 0", rdy_viol - rdy0); end
      while (exp_addr_q.size() != 0) begin
         ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
         checks++;
         if (obs_addr_q.size() == 0) begin errors++; $display("FAIL slow_write: missing write to %08h", ea); end
         else begin
            if ({obs_addr_q[0], obs_data_q[0], obs_strb_q[0]} !== {ea, ed, 4'hF}) begin
               errors++; $display("FAIL slow_write: got %08h/%08h/%h want %08h/%08h/F",
                                  obs_addr_q[0], obs_data_q[0], obs_strb_q[0], ea, ed);
            end
            void'(obs_addr_q.pop_front()); void'(obs_data_q.pop_front()); void'(obs_strb_q.pop_front());
         end
      end
      disarm();
      bresp_val = 2'b10;
      isp_en_i = 1'b1;
      send_word(32'd2);
      send_data(32'hCAFE_0042, 0);
      wait_status();
      checks++;
      if ({err_o, err_code_o, word_cnt_o} !== {1'b1, 3'd3, 16'd0}) begin
         errors++; $display("FAIL bresp_err: err=%b code=%0d cnt=%0d, want 1 3 0", err_o, err_code_o, word_cnt_o);
      end
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
      checks++;
      if (obs_addr_q.size() != 1) begin errors++; $display("FAIL bresp_write: %0d writes, want 1", obs_addr_q.size()); end
      else begin
         if ({obs_addr_q[0], obs_data_q[0]} !== {ea, ed}) begin
            errors++; $display("FAIL bresp_write: got %08h/%08h want %08h/%08h", obs_addr_q[0], obs_data_q[0], ea, ed);
         end
      end
      obs_addr_q.delete(); obs_data_q.delete(); obs_strb_q.delete();
      bresp_val = 2'b00; aw_delay = 0; w_delay = 0; b_delay = 0;
      disarm();
   endtask

   task automatic test_timeout();
      int n, act0;
      act0 = act_cnt;
      isp_en_i = 1'b1;
      send_word(32'd2);
      send_byte(8'h11);
      send_byte(8'h22);
      for (n = 1; n <= 300; n++) begin
         @(posedge clk); #1;
         if (err_o) break;
      end
      checks++;
      if (n != 100 || err_code_o !== 3'd4) begin
         errors++; $display("FAIL timeout: err after %0d cycles code=%0d, want 100 and 4", n, err_code_o);
      end
      checks++;
      if (act_cnt != act0) begin errors++; $display("FAIL timeout_no_axi: %0d valid cycles, want 0", act_cnt - act0); end
      disarm();
   endtask

   task automatic test_abort_wait_b();
      logic [31:0] ea, ed;
      int hs0;
      b_delay = 10;
      isp_en_i = 1'b1;
      send_word(32'd1);
      send_data(32'hDEAD_BEEF, 0);
      for (int n = 0; n < 50 && !isp_axi_bready; n++) @(negedge clk);
      hs0 = b_hs;
      isp_en_i = 1'b0;
      @(negedge clk);
      checks++;
      if ({isp_axi_bready, busy_o} !== 2'b11) begin
         errors++; $display("FAIL abort_hold: bready=%b busy=%b, want 1 1 while B pending", isp_axi_bready, busy_o);
      end
      for (int n = 0; n < 50 && b_hs == hs0; n++) @(negedge clk);
      checks++;
      if (b_hs != hs0 + 1) begin errors++; $display("FAIL abort_bhs: %0d B handshakes, want 1", b_hs - hs0); end
      checks++;
      if ({busy_o, done_o, err_o, err_code_o, word_cnt_o, isp_axi_bready} !== 22'd0) begin
         errors++; $display("FAIL abort_idle: busy=%b done=%b err=%b code=%0d cnt=%0d bready=%b, want all 0",
                            busy_o, done_o, err_o, err_code_o, word_cnt_o, isp_axi_bready);
      end
      ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
      checks++;
      if (obs_addr_q.size() != 1 || {obs_addr_q[0], obs_data_q[0]} !== {ea, ed}) begin
         errors++; $display("FAIL abort_write: %0d writes first %08h/%08h, want 1 of %08h/%08h",
                            obs_addr_q.size(), obs_addr_q.size() ? obs_addr_q[0] : 32'd0,
                            obs_data_q.size() ? obs_data_q[0] : 32'd0, ea, ed);
      end
      obs_addr_q.delete(); obs_data_q.delete(); obs_strb_q.delete();
      b_delay = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_data();
      logic [31:0] ea, ed;
      isp_en_i = 1'b1;
      send_word(32'd2);
      send_byte(8'h77);
      send_byte(8'h88);
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({busy_o, rx_ready_o, done_o, err_o, err_code_o, word_cnt_o, isp_axi_awvalid, isp_axi_wvalid,
           isp_axi_bready, isp_axi_awaddr, isp_axi_wdata} !== 93'd0) begin
         errors++; $display("FAIL reset_mid: busy=%b rdy=%b cnt=%0d awv=%b wv=%b, want all 0",
                            busy_o, rx_ready_o, word_cnt_o, isp_axi_awvalid, isp_axi_wvalid);
      end
      rst_n = 1'b1;
      send_word(32'd3);
      send_data(32'h0000_0001, 0);
      send_data(32'h0000_0002, 1);
      send_data(32'hFFFF_FFFF, 2);
      send_word(32'h0000_0002);
      wait_status();
      checks++;
      if ({done_o, err_o, word_cnt_o} !== {1'b1, 1'b0, 16'd3}) begin
         errors++; $display("FAIL reload_status: done=%b err=%b cnt=%0d, want 1 0 3", done_o, err_o, word_cnt_o);
      end
      while (exp_addr_q.size() != 0) begin
         ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
         checks++;
         if (obs_addr_q.size() == 0) begin errors++; $display("FAIL reload_write: missing write to %08h", ea); end
         else begin
            if ({obs_addr_q[0], obs_data_q[0]} !== {ea, ed}) begin
               errors++; $display("FAIL reload_write: got %08h/%08h want %08h/%08h", obs_addr_q[0], obs_data_q[0], ea, ed);
            end
            void'(obs_addr_q.pop_front()); void'(obs_data_q.pop_front()); void'(obs_strb_q.pop_front());
         end
      end
      disarm();
   endtask

   task automatic test_protocol();
      checks++;
      if (hold_viol != 0) begin errors++; $display("FAIL valid_hold: %0d withdrawn valids, want 0", hold_viol); end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_bad_length();
      test_slow_slave();
      test_timeout();
      test_abort_wait_b();
      test_reset_mid_data();
      test_protocol();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/iram_isp_loader.md
Name: iram_isp_loader

Overview:
- In-system-programming loader that fills instruction RAM from a byte stream (UART receiver or debug link) through the iram AXI4-Lite slave write channels.
- Parses a framed image: length word, payload words, checksum word.
- Issues one AXI4-Lite write per payload word and reports done or error to the ISP boot code.
- Sits between the UART RX byte interface and the AXI write path of iram; it never reads.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first payload word (word aligned).
- MAX_WORDS, 8192, maximum accepted payload length in words.
- TIMEOUT, 24'd1_000_000, idle cycles allowed between bytes before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- isp_en_i  in  1  arm loader; deassert to abort or clear status
- rx_data_i  in  8  stream byte
- rx_valid_i  in  1  byte valid
- rx_ready_o  out  1  byte accepted when rx_valid_i & rx_ready_o
- isp_axi_awaddr  out  32  write address
- isp_axi_awprot  out  3  constant 3'b000
- isp_axi_awvalid  out  1  write address valid
- isp_axi_awready  in  1  write address ready
- isp_axi_wdata  out  32  write data
- isp_axi_wstrb  out  4  constant 4'hF
- isp_axi_wvalid  out  1  write data valid
- isp_axi_wready  in  1  write data ready
- isp_axi_bresp  in  2  write response
- isp_axi_bvalid  in  1  write response valid
- isp_axi_bready  out  1  write response ready
- busy_o  out  1  frame in progress
- done_o  out  1  frame loaded and checksum good; sticky until isp_en_i=0
- err_o  out  1  frame failed; sticky until isp_en_i=0
- err_code_o  out  3  1=len 0 or >MAX_WORDS, 2=checksum mismatch, 3=bresp!=0, 4=timeout
- word_cnt_o  out  16  payload words written so far

Behaviour:
- Clock is clk; reset is synchronous and active-low on rst_n. All state is sampled on the rising edge of clk.
- Reset values: state IDLE; every output 0 except the constants awprot=0 and wstrb=F.
- Bytes are little-endian: the first byte is bits [7:0]. A 2-bit byte index assembles each word.
- States and transitions:
  - IDLE: if isp_en_i=1 and neither done nor err is set, go to LEN.
  - LEN: on the 4th byte, latch len. If len==0 or len>MAX_WORDS, go to ERR(1). Otherwise clear word_cnt and sum, go to DATA.
  - DATA: on the 4th byte, latch wdata, set awaddr=BASE_ADDR+4*word_cnt, assert awvalid and wvalid together, go to WR.
  - WR: drop awvalid on the cycle after awvalid&awready; drop wvalid on the cycle after wvalid&wready. The two may complete in the same or different cycles. When both have completed, go to WAIT_B. iram asserts both readys together, but the block must not depend on that.
  - WAIT_B: bready=1. On bvalid:
    - bresp!=0: go to ERR(3).
    - otherwise: sum+=wdata (mod 2^32) and word_cnt+=1. If word_cnt==len go to CSUM, else go to DATA.
  - CSUM: on the 4th byte, compare with sum. Equal: go to DONE. Different: go to ERR(2).
  - DONE: done_o=1. Leave to IDLE when isp_en_i=0.
  - ERR: err_o=1 with err_code_o. Leave to IDLE when isp_en_i=0.
- rx_ready_o=1 only in LEN, DATA and CSUM, and only when isp_en_i=1. It is 0 in WR and WAIT_B (backpressure), so no byte is lost or buffered.
- busy_o=1 in LEN, DATA, WR, WAIT_B and CSUM.
- Timeout: in LEN/DATA/CSUM, a counter resets on each accepted byte. Reaching TIMEOUT goes to ERR(4). WR and WAIT_B are not timed.
- Abort (isp_en_i=0):
  - In LEN/DATA/CSUM: go to IDLE next cycle and discard the partial word.
  - In WR/WAIT_B: valids are held until the handshakes complete and bvalid is taken. Then go to IDLE. AXI valids are never withdrawn.
- Status clear: done_o, err_o, err_code_o and word_cnt_o clear when returning to IDLE. word_cnt_o otherwise holds its last value.
- Address arithmetic is 32-bit wrap. There is no range check beyond MAX_WORDS.
- Reset mid-transaction returns to IDLE immediately. The attached slave is reset by the same rst_n.

Test Plan:
- Frame len=2, words 0x00000013,0x12345678, csum 0x1234568B. Slave ready always. Required: two writes, to addr 0x0 and 0x4, both wstrb F. Then done_o=1, word_cnt_o=2, err_o=0.
- Same frame with csum 0x00000000. Required: both writes occur, then err_o=1, err_code_o=2.
- len=0, then len=MAX_WORDS+1 on a re-arm. Required: err_code_o=1 each time, no AW/W activity, rx_ready_o=0 after the 4th length byte.
- Slave awready 3 cycles before wready, bvalid delayed 5 cycles. Required: awvalid falls before wvalid, rx_ready_o=0 throughout, data intact. Then bresp=2'b10. Required: err_code_o=3.
- TIMEOUT=100, stop after 2 payload bytes. Required: err_code_o=4 at 100 cycles. Separately, drop isp_en_i during WAIT_B. Required: B handshake completes, then IDLE with all status cleared.
- rst_n=0 for 1 cycle mid-DATA. Required: all outputs 0 next cycle, and a fresh frame then loads correctly.
